risc_control_unit: RTL and testbench

RISC_CONTROL_UNIT -- requirements
Module: risc_control_unit

---
 rtl/risc_control_unit.sv | 205 ++++++++++++++++++++
 tb/tb_risc_control_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_control_unit.sv
// rtl/risc_control_unit.sv - Moore control FSM sequencing fetch/execute strobes for a small RISC datapath
module risc_control_unit #(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stop,
    input  logic [31:0] ir,
    output logic        run,
    output logic [18:0] ctrl,
    output logic [4:0]  alu_op,
    output logic        instr_done
);

    localparam int B_PCOUT   = 0;
    localparam int B_INCPC   = 1;
    localparam int B_MARIN   = 2;
    localparam int B_READ    = 3;
    localparam int B_WRITE   = 4;
    localparam int B_MDRIN   = 5;
    localparam int B_MDROUT  = 6;
    localparam int B_IRIN    = 7;
    localparam int B_GRA     = 8;
    localparam int B_GRB     = 9;
    localparam int B_GRC     = 10;
    localparam int B_RIN     = 11;
    localparam int B_ROUT    = 12;
    localparam int B_BAOUT   = 13;
    localparam int B_COUT    = 14;
    localparam int B_YIN     = 15;
    localparam int B_ZIN     = 16;
    localparam int B_ZLOWOUT = 17;
    localparam int B_CLEAR   = 18;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wait_q, wait_d;

    logic [4:0] opcode;
    logic       is_alu_r, is_alu_i, is_ld, is_st, is_halt, is_mem;
    logic       wait_done;

    assign opcode    = ir[31:27];
    assign is_alu_r  = (opcode <= 5'h0B);
    assign is_alu_i  = (opcode == 5'h0C) || (opcode == 5'h0D) || (opcode == 5'h0E);
    assign is_ld     = (opcode == 5'h10);
    assign is_st     = (opcode == 5'h11);
    assign is_halt   = (opcode == 5'h1B);
    assign is_mem    = is_ld || is_st;
    assign wait_done = (wait_q == WAIT_LAST);

    // The wait counter only advances while parked in a wait state; every transition clears it.
    always_comb begin
        state_d = S_RST;
        wait_d  = 4'd0;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = stop ? S_HALT : S_T1;
            S_T1: begin
                if (wait_done) begin
                    state_d = S_T2;
                end else begin
                    state_d = S_T1;
                    wait_d  = wait_q + 4'd1;
                end
            end
            S_T2:   state_d = S_T3;
            S_T3: begin
                if (is_alu_r || is_alu_i || is_mem) state_d = S_T4;
                else if (is_halt)                   state_d = S_HALT;
                else                                state_d = S_T0;
            end
            S_T4:   state_d = S_T5;
            S_T5:   state_d = is_mem ? S_T6 : S_T0;
            S_T6: begin
                if (is_ld && !wait_done) begin
                    state_d = S_T6;
                    wait_d  = wait_q + 4'd1;
                end else if (is_mem) begin
                    state_d = S_T7;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T7: begin
                if (is_st && !wait_done) begin
                    state_d = S_T7;
                    wait_d  = wait_q + 4'd1;
                end else begin
                    state_d = S_T0;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RST;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        ctrl       = 19'd0;
        alu_op     = 5'h00;
        instr_done = 1'b0;
        case (state_q)
            S_RST: ctrl[B_CLEAR] = 1'b1;
            S_T0: begin
                ctrl[B_PCOUT] = 1'b1;
                ctrl[B_MARIN] = 1'b1;
                ctrl[B_INCPC] = 1'b1;
            end
            S_T1: begin
                ctrl[B_READ]  = 1'b1;
                ctrl[B_MDRIN] = 1'b1;
            end
            S_T2: begin
                ctrl[B_MDROUT] = 1'b1;
                ctrl[B_IRIN]   = 1'b1;
            end
            S_T3: begin
                if (is_alu_r || is_alu_i) begin
                    ctrl[B_GRB]  = 1'b1;
                    ctrl[B_ROUT] = 1'b1;
                    ctrl[B_YIN]  = 1'b1;
                end else if (is_mem) begin
                    ctrl[B_GRB]   = 1'b1;
                    ctrl[B_BAOUT] = 1'b1;
                    ctrl[B_YIN]   = 1'b1;
                end else begin
                    instr_done = 1'b1;
                end
            end
            S_T4: begin
                if (is_alu_r) begin
                    ctrl[B_GRC]  = 1'b1;
                    ctrl[B_ROUT] = 1'b1;
                    ctrl[B_ZIN]  = 1'b1;
                    alu_op       = opcode;
                end else if (is_alu_i || is_mem) begin
                    ctrl[B_COUT] = 1'b1;
                    ctrl[B_ZIN]  = 1'b1;
                    // Immediate forms reuse the register-form ALU encodings: add, and, or.
                    if (opcode == 5'h0D)      alu_op = 5'h02;
                    else if (opcode == 5'h0E) alu_op = 5'h03;
                    else                      alu_op = 5'h00;
                end
            end
            S_T5: begin
                ctrl[B_ZLOWOUT] = 1'b1;
                if (is_mem) begin
                    ctrl[B_MARIN] = 1'b1;
                end else begin
                    ctrl[B_GRA] = 1'b1;
                    ctrl[B_RIN] = 1'b1;
                    instr_done  = 1'b1;
                end
            end
            S_T6: begin
                ctrl[B_MDRIN] = 1'b1;
                if (is_ld) begin
                    ctrl[B_READ] = 1'b1;
                end else begin
                    ctrl[B_GRA]  = 1'b1;
                    ctrl[B_ROUT] = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    ctrl[B_MDROUT] = 1'b1;
                    ctrl[B_GRA]    = 1'b1;
                    ctrl[B_RIN]    = 1'b1;
                    instr_done     = 1'b1;
                end else begin
                    ctrl[B_WRITE] = 1'b1;
                    instr_done    = wait_done;
                end
            end
            default: ;
        endcase
    end

    assign run = (state_q != S_RST) && (state_q != S_HALT);

endmodule

// File: tb/tb_risc_control_unit.sv
// tb/tb_risc_control_unit.sv - scoreboard bench replaying per-cycle expected strobes for three MEM_WAIT settings
module tb_risc_control_unit;

    localparam logic [18:0] PCOUT   = 19'h00001;
    localparam logic [18:0] INCPC   = 19'h00002;
    localparam logic [18:0] MARIN   = 19'h00004;
    localparam logic [18:0] READ    = 19'h00008;
    localparam logic [18:0] WRITE   = 19'h00010;
    localparam logic [18:0] MDRIN   = 19'h00020;
    localparam logic [18:0] MDROUT  = 19'h00040;
    localparam logic [18:0] IRIN    = 19'h00080;
    localparam logic [18:0] GRA     = 19'h00100;
    localparam logic [18:0] GRB     = 19'h00200;
    localparam logic [18:0] GRC     = 19'h00400;
    localparam logic [18:0] RIN     = 19'h00800;
    localparam logic [18:0] ROUT    = 19'h01000;
    localparam logic [18:0] BAOUT   = 19'h02000;
    localparam logic [18:0] COUT    = 19'h04000;
    localparam logic [18:0] YIN     = 19'h08000;
    localparam logic [18:0] ZIN     = 19'h10000;
    localparam logic [18:0] ZLOWOUT = 19'h20000;
    localparam logic [18:0] CLEAR   = 19'h40000;

    typedef struct {
        logic [31:0] ir_v;
        logic        stp;
        logic        rs;
        logic [18:0] c;
        logic [4:0]  a;
        logic        d;
        logic        r;
        logic        chk;
    } rec_t;

    logic              clock = 1'b0;
    logic [2:0]        rst_v = 3'b111;
    logic              stop  = 1'b0;
    logic [31:0]       ir    = 32'd0;
    logic [2:0]        run_w;
    logic [2:0][18:0]  ctrl_w;
    logic [2:0][4:0]   alu_w;
    logic [2:0]        done_w;

    rec_t sb[$];
    int   sel = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned MW = (g == 0) ? 0 : (g == 1) ? 2 : 3;
        risc_control_unit #(.MEM_WAIT(MW)) u_dut (
            .clock      (clock),
            .reset      (rst_v[g]),
            .stop       (stop),
            .ir         (ir),
            .run        (run_w[g]),
            .ctrl       (ctrl_w[g]),
            .alu_op     (alu_w[g]),
            .instr_done (done_w[g])
        );
    end

    function automatic logic [31:0] mk(input logic [4:0] op);
        return {op, 4'd1, 4'd2, 4'd3, 15'd0};
    endfunction

    task automatic push(input logic [31:0] ir_v, input logic stp, input logic rs,
                        input logic [18:0] c, input logic [4:0] a, input logic d,
                        input logic r, input logic chk);
        rec_t e;
        e.ir_v = ir_v; e.stp = stp; e.rs = rs; e.c = c;
        e.a = a; e.d = d; e.r = r; e.chk = chk;
        sb.push_back(e);
    endtask

    task automatic push_rst(input logic [31:0] ir_v);
        push(ir_v, 1'b0, 1'b0, CLEAR, 5'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push_halt(input int n, input logic rs_last);
        for (int i = 0; i < n; i++)
            push(32'd0, 1'b0, rs_last && (i == n - 1), 19'd0, 5'h00, 1'b0, 1'b0, 1'b1);
    endtask

    // Expected cycle stream for one instruction starting at T0; rst_t7 asserts reset in that T7 cycle.
    task automatic push_instr(input logic [4:0] op, input int mw, input logic stop_t4, input int rst_t7);
        logic [31:0] v;
        logic [4:0]  ia;
        v = mk(op);
        push(v, 1'b0, 1'b0, PCOUT | INCPC | MARIN, 5'h00, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i <= mw; i++)
            push(v, 1'b0, 1'b0, READ | MDRIN, 5'h00, 1'b0, 1'b1, 1'b1);
        push(v, 1'b0, 1'b0, MDROUT | IRIN, 5'h00, 1'b0, 1'b1, 1'b1);
        if (op <= 5'h0E) begin
            ia = (op == 5'h0C) ? 5'h00 : (op == 5'h0D) ? 5'h02 : (op == 5'h0E) ? 5'h03 : op;
            push(v, 1'b0, 1'b0, GRB | ROUT | YIN, 5'h00, 1'b0, 1'b1, 1'b1);
            if (op <= 5'h0B)
                push(v, stop_t4, 1'b0, GRC | ROUT | ZIN, ia, 1'b0, 1'b1, 1'b1);
            else
                push(v, stop_t4, 1'b0, COUT | ZIN, ia, 1'b0, 1'b1, 1'b1);
            push(v, 1'b0, 1'b0, ZLOWOUT | GRA | RIN, 5'h00, 1'b1, 1'b1, 1'b1);
        end else if (op == 5'h10 || op == 5'h11) begin
            push(v, 1'b0, 1'b0, GRB | BAOUT | YIN, 5'h00, 1'b0, 1'b1, 1'b1);
            push(v, 1'b0, 1'b0, COUT | ZIN, 5'h00, 1'b0, 1'b1, 1'b1);
            push(v, 1'b0, 1'b0, ZLOWOUT | MARIN, 5'h00, 1'b0, 1'b1, 1'b1);
            if (op == 5'h10) begin
                for (int i = 0; i <= mw; i++)
                    push(v, 1'b0, 1'b0, READ | MDRIN, 5'h00, 1'b0, 1'b1, 1'b1);
                push(v, 1'b0, 1'b0, MDROUT | GRA | RIN, 5'h00, 1'b1, 1'b1, 1'b1);
            end else begin
                push(v, 1'b0, 1'b0, GRA | ROUT | MDRIN, 5'h00, 1'b0, 1'b1, 1'b1);
                for (int i = 0; i <= mw; i++) begin
                    push(v, 1'b0, (i == rst_t7), WRITE, 5'h00, (i == mw), 1'b1, 1'b1);
                    if (i == rst_t7) break;
                end
            end
        end else begin
            push(v, 1'b0, 1'b0, 19'd0, 5'h00, 1'b1, 1'b1, 1'b1);
        end
    endtask

    task automatic run_queue(input int inst);
        rec_t e;
        int   cyc;
        sel = inst;
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            stop = e.stp;
            ir = e.ir_v;
            rst_v[inst] = e.rs;
            @(negedge clock);
            if (e.chk) begin
                n_cmp++;
                assert (ctrl_w[inst] === e.c) else begin
                    n_bad++;
                    $error("FAIL ctrl inst%0d cyc%0d observed=%05h expected=%05h", inst, cyc, ctrl_w[inst], e.c);
                end
            end
            n_cmp++;
            assert (alu_w[inst] === e.a) else begin
                n_bad++;
                $error("FAIL alu_op inst%0d cyc%0d observed=%02h expected=%02h", inst, cyc, alu_w[inst], e.a);
            end
            n_cmp++;
            assert (done_w[inst] === e.d) else begin
                n_bad++;
                $error("FAIL instr_done inst%0d cyc%0d observed=%b expected=%b", inst, cyc, done_w[inst], e.d);
            end
            n_cmp++;
            assert (run_w[inst] === e.r) else begin
                n_bad++;
                $error("FAIL run inst%0d cyc%0d observed=%b expected=%b", inst, cyc, run_w[inst], e.r);
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        stop = 1'b0;
        rst_v[inst] = 1'b1;
    endtask

    initial begin
        @(posedge clock);
        #1;

        // MEM_WAIT=0: ALU forms, store, unknown opcodes, stop handling, halt instruction.
        push_rst(mk(5'h03));
        push_instr(5'h03, 0, 1'b0, -1);
        push_instr(5'h0E, 0, 1'b0, -1);
        push_instr(5'h0D, 0, 1'b0, -1);
        push_instr(5'h0C, 0, 1'b0, -1);
        push_instr(5'h11, 0, 1'b0, -1);
        push_instr(5'h1F, 0, 1'b0, -1);
        push_instr(5'h1A, 0, 1'b0, -1);
        push_instr(5'h0B, 0, 1'b1, -1);
        push_instr(5'h03, 0, 1'b0, -1);
        push(mk(5'h03), 1'b1, 1'b0, 19'd0, 5'h00, 1'b0, 1'b1, 1'b0);
        push_halt(20, 1'b1);
        push_rst(mk(5'h1B));
        push_instr(5'h1B, 0, 1'b0, -1);
        push_halt(4, 1'b0);
        run_queue(0);

        // MEM_WAIT=2: load stretches both reads to three cycles.
        push_rst(mk(5'h10));
        push_instr(5'h10, 2, 1'b0, -1);
        push_instr(5'h01, 2, 1'b0, -1);
        run_queue(1);

        // MEM_WAIT=3: reset lands in the second write cycle of a store.
        push_rst(mk(5'h11));
        push_instr(5'h11, 3, 1'b0, 1);
        push_rst(mk(5'h11));
        push(mk(5'h11), 1'b0, 1'b0, PCOUT | INCPC | MARIN, 5'h00, 1'b0, 1'b1, 1'b1);
        run_queue(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
